maccum_mode_scheduler: RTL and testbench

- Shares one forward multiply-accumulate stage between two state requesters: a TRAIN sample stream and a TEST sample stream.
- Drives the stage's mode select and forwards the granted requester's state token onto the stage's State0 input.
- Mode changes only after every token already issued has left the stage's Accum0 output. Results therefore never carry the wrong mode.
- Sits directly upstream of the forward maccum and observes its Accum0 handshake passively.

---
 rtl/maccum_mode_scheduler_pkg.sv | 24 ++
 rtl/maccum_mode_scheduler_inflight_counter.sv | 39 +++
 rtl/maccum_mode_scheduler.sv | 160 ++++++++++++++++
 tb/tb_maccum_mode_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maccum_mode_scheduler_pkg.sv
// Shared TRAIN/TEST mode encoding and scheduler FSM state encoding for maccum_mode_scheduler.
package maccum_mode_scheduler_pkg;

    typedef enum logic {
        MODE_TEST  = 1'b0,
        MODE_TRAIN = 1'b1
    } mode_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SWITCH    = 2'd1,
        RUN_TRAIN = 2'd2,
        RUN_TEST  = 2'd3
    } state_t;

    function automatic mode_t flip_mode(input mode_t m);
        return (m == MODE_TRAIN) ? MODE_TEST : MODE_TRAIN;
    endfunction

    function automatic state_t run_state(input mode_t m);
        return (m == MODE_TRAIN) ? RUN_TRAIN : RUN_TEST;
    endfunction

endpackage

// File: rtl/maccum_mode_scheduler_inflight_counter.sv
// Up/down count of tokens inside the maccum stage, with full/empty flags
// and a sticky underflow error when a retire is seen with nothing in flight.
module maccum_inflight_counter #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue,
    input  logic          retire,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          error
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            error <= 1'b0;
        end else begin
            if (issue && !retire) begin
                count <= count + ONE_C;
            end else if (retire && !issue && !empty) begin
                count <= count - ONE_C;
            end
            if (retire && empty) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/maccum_mode_scheduler.sv
// Arbitrates TRAIN/TEST state requesters onto one forward maccum, switching mode only when drained.
// Optional performance counters: define MACCUM_MODE_SCHEDULER_PERF_EN.
module maccum_mode_scheduler
    import maccum_mode_scheduler_pkg::*;
#(
    parameter int NP     = 7,
    parameter int WF     = 5,
    parameter int DEPTH  = 8,
    parameter int MAXRUN = 16
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iValid_AS_Train,
    output logic             oReady_AS_Train,
    input  logic [NP*WF-1:0] iData_AS_Train,
    input  logic             iValid_AS_Test,
    output logic             oReady_AS_Test,
    input  logic [NP*WF-1:0] iData_AS_Test,
    output logic             oValid_BM_State,
    input  logic             iReady_BM_State,
    output logic [NP*WF-1:0] oData_BM_State,
    output logic             oMode,
    input  logic             iValid_MON_Accum,
    input  logic             iReady_MON_Accum,
    output logic             oBusy,
    output logic             oError
`ifdef MACCUM_MODE_SCHEDULER_PERF_EN
    ,
    output logic [31:0]      oCnt_Train,
    output logic [31:0]      oCnt_Test,
    output logic [15:0]      oCnt_Switch
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = $clog2(MAXRUN + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(MAXRUN);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    state_t        state, state_next;
    mode_t         mode, mode_next;
    mode_t         last, last_next;
    mode_t         serving, want;
    logic [RW-1:0] runcnt, run_next;
    logic [CW-1:0] inflight;
    logic          full, empty;
    logic          issue, retire, drained;
    logic          mine_valid, other_valid;

    assign issue   = oValid_BM_State & iReady_BM_State;
    assign retire  = iValid_MON_Accum & iReady_MON_Accum;
    // A retire in the current cycle lets SWITCH leave one cycle earlier.
    assign drained = empty | ((inflight == ONE_C) & retire);

    maccum_inflight_counter #(
        .DEPTH (DEPTH)
    ) u_inflight (
        .clk    (iCLK),
        .rst_n  (iRST),
        .issue  (issue),
        .retire (retire),
        .count  (inflight),
        .full   (full),
        .empty  (empty),
        .error  (oError)
    );

    assign serving     = (state == RUN_TRAIN) ? MODE_TRAIN : MODE_TEST;
    assign mine_valid  = (serving == MODE_TRAIN) ? iValid_AS_Train : iValid_AS_Test;
    assign other_valid = (serving == MODE_TRAIN) ? iValid_AS_Test : iValid_AS_Train;
    assign want        = (iValid_AS_Train && iValid_AS_Test) ? flip_mode(last)
                       : (iValid_AS_Train ? MODE_TRAIN : MODE_TEST);

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state  <= IDLE;
            mode   <= MODE_TEST;
            last   <= MODE_TRAIN;
            runcnt <= '0;
        end else begin
            state  <= state_next;
            mode   <= mode_next;
            last   <= last_next;
            runcnt <= run_next;
        end
    end

    always_comb begin
        state_next = state;
        mode_next  = mode;
        last_next  = last;
        run_next   = runcnt;
        unique case (state)
            IDLE: begin
                run_next = '0;
                if (iValid_AS_Train || iValid_AS_Test) begin
                    state_next = (want == mode) ? run_state(want) : SWITCH;
                end
            end
            SWITCH: begin
                if (drained) begin
                    mode_next  = flip_mode(mode);
                    state_next = run_state(flip_mode(mode));
                end
            end
            RUN_TRAIN, RUN_TEST: begin
                if (issue) begin
                    last_next = serving;
                    if (runcnt != RUN_MAX) begin
                        run_next = runcnt + RW'(1);
                    end
                end
                if (other_valid && (!mine_valid || run_next == RUN_MAX)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        oValid_BM_State = 1'b0;
        oReady_AS_Train = 1'b0;
        oReady_AS_Test  = 1'b0;
        oData_BM_State  = '0;
        unique case (state)
            RUN_TRAIN: begin
                oValid_BM_State = iValid_AS_Train & ~full;
                oReady_AS_Train = iReady_BM_State & ~full;
                oData_BM_State  = iData_AS_Train;
            end
            RUN_TEST: begin
                oValid_BM_State = iValid_AS_Test & ~full;
                oReady_AS_Test  = iReady_BM_State & ~full;
                oData_BM_State  = iData_AS_Test;
            end
            default: ;
        endcase
    end

    assign oMode = mode;
    assign oBusy = ~empty | (state != IDLE);

`ifdef MACCUM_MODE_SCHEDULER_PERF_EN
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oCnt_Train  <= '0;
            oCnt_Test   <= '0;
            oCnt_Switch <= '0;
        end else begin
            if (issue && state == RUN_TRAIN) oCnt_Train <= oCnt_Train + 32'd1;
            if (issue && state == RUN_TEST)  oCnt_Test  <= oCnt_Test + 32'd1;
            if (state == SWITCH && state_next != SWITCH && oCnt_Switch != '1) begin
                oCnt_Switch <= oCnt_Switch + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_maccum_mode_scheduler.sv
// Bench for maccum_mode_scheduler: directed scenarios plus random traffic, all checked
// every cycle against a behavioural model of the scheduling rules.
module tb_maccum_mode_scheduler;
    import maccum_mode_scheduler_pkg::*;

    localparam int NP     = 7;
    localparam int WF     = 5;
    localparam int DW     = NP * WF;
    localparam int DEPTH  = 4;
    localparam int MAXRUN = 4;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b0;
    logic          v_tr = 1'b0, v_te = 1'b0, rdy_bm = 1'b0, mon_v = 1'b0, mon_r = 1'b0;
    logic [DW-1:0] d_tr = '0, d_te = '0;
    logic          o_rdy_tr, o_rdy_te, o_valid, o_mode, o_busy, o_err;
    logic [DW-1:0] o_data;
`ifdef MACCUM_MODE_SCHEDULER_PERF_EN
    logic [31:0]   c_tr, c_te;
    logic [15:0]   c_sw;
`endif

    always #5 iCLK = ~iCLK;

    maccum_mode_scheduler #(
        .NP     (NP),
        .WF     (WF),
        .DEPTH  (DEPTH),
        .MAXRUN (MAXRUN)
    ) dut (
        .iCLK             (iCLK),
        .iRST             (iRST),
        .iValid_AS_Train  (v_tr),
        .oReady_AS_Train  (o_rdy_tr),
        .iData_AS_Train   (d_tr),
        .iValid_AS_Test   (v_te),
        .oReady_AS_Test   (o_rdy_te),
        .iData_AS_Test    (d_te),
        .oValid_BM_State  (o_valid),
        .iReady_BM_State  (rdy_bm),
        .oData_BM_State   (o_data),
        .oMode            (o_mode),
        .iValid_MON_Accum (mon_v),
        .iReady_MON_Accum (mon_r),
        .oBusy            (o_busy),
        .oError           (o_err)
`ifdef MACCUM_MODE_SCHEDULER_PERF_EN
        ,
        .oCnt_Train       (c_tr),
        .oCnt_Test        (c_te),
        .oCnt_Switch      (c_sw)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Model state: phase 0 = no grant, 1 = waiting for drain before flipping mode, 2 = serving.
    int          m_inflight, m_run, m_phase;
    bit          m_err, m_mode_train, m_who_train, m_last_train;
    logic [31:0] m_cnt_tr, m_cnt_te;
    int          m_cnt_sw;
    int          cyc = 0;
    bit          took_tr, took_te, dut_issue;

    task automatic model_reset();
        m_inflight = 0; m_run = 0; m_phase = 0; m_err = 0;
        m_mode_train = 0; m_who_train = 0; m_last_train = 1;
        m_cnt_tr = '0; m_cnt_te = '0; m_cnt_sw = 0;
        took_tr = 0; took_te = 0;
    endtask

    task automatic do_reset();
        @(negedge iCLK);
        #2;
        iRST = 1'b0;
        #1;
        chk("rst_valid", 64'(o_valid), 64'(0));
        chk("rst_rdy_tr", 64'(o_rdy_tr), 64'(0));
        chk("rst_rdy_te", 64'(o_rdy_te), 64'(0));
        chk("rst_data", 64'(o_data), 64'(0));
        chk("rst_mode", 64'(o_mode), 64'(MODE_TEST));
        chk("rst_busy", 64'(o_busy), 64'(0));
        chk("rst_err", 64'(o_err), 64'(0));
`ifdef MACCUM_MODE_SCHEDULER_PERF_EN
        chk("rst_cnt_tr", 64'(c_tr), 64'(0));
        chk("rst_cnt_te", 64'(c_te), 64'(0));
        chk("rst_cnt_sw", 64'(c_sw), 64'(0));
`endif
        v_tr = 0; v_te = 0; rdy_bm = 0; mon_v = 0; mon_r = 0;
        model_reset();
        repeat (2) @(negedge iCLK);
        iRST = 1'b1;
    endtask

    task automatic step(input bit vtr, input bit vte, input bit rdy, input bit mv, input bit mr);
        bit            room, serving, e_valid, issue, retire, want_tr, mine, other;
        logic [DW-1:0] e_data;
        mode_t         e_mode;
        @(negedge iCLK);
        if (!(v_tr && !took_tr)) d_tr = DW'({$urandom(), $urandom()});
        if (!(v_te && !took_te)) d_te = DW'({$urandom(), $urandom()});
        v_tr = vtr; v_te = vte; rdy_bm = rdy; mon_v = mv; mon_r = mr;
        #1;
        serving = (m_phase == 2);
        room    = (m_inflight < DEPTH);
        e_valid = serving && room && (m_who_train ? vtr : vte);
        e_data  = !serving ? '0 : (m_who_train ? d_tr : d_te);
        e_mode  = m_mode_train ? MODE_TRAIN : MODE_TEST;
        chk("valid", 64'(o_valid), 64'(e_valid));
        chk("rdy_tr", 64'(o_rdy_tr), 64'(serving && room && m_who_train && rdy));
        chk("rdy_te", 64'(o_rdy_te), 64'(serving && room && !m_who_train && rdy));
        chk("data", 64'(o_data), 64'(e_data));
        chk("mode", 64'(o_mode), 64'(e_mode));
        chk("busy", 64'(o_busy), 64'(m_inflight != 0 || m_phase != 0));
        chk("err", 64'(o_err), 64'(m_err));
`ifdef MACCUM_MODE_SCHEDULER_PERF_EN
        chk("cnt_tr", 64'(c_tr), 64'(m_cnt_tr));
        chk("cnt_te", 64'(c_te), 64'(m_cnt_te));
        chk("cnt_sw", 64'(c_sw), 64'(m_cnt_sw));
`endif
        dut_issue = o_valid && rdy_bm;
        issue     = e_valid && rdy;
        retire    = mv && mr;
        took_tr   = issue && m_who_train;
        took_te   = issue && !m_who_train;
        cyc++;

        if (retire && m_inflight == 0) m_err = 1;
        if (issue && !retire) m_inflight++;
        else if (retire && !issue && m_inflight > 0) m_inflight--;

        case (m_phase)
            0: begin
                m_run = 0;
                if (vtr || vte) begin
                    want_tr = (vtr && vte) ? !m_last_train : vtr;
                    if (want_tr == m_mode_train) begin
                        m_phase = 2; m_who_train = want_tr;
                    end else begin
                        m_phase = 1;
                    end
                end
            end
            1: if (m_inflight == 0) begin
                m_mode_train = !m_mode_train;
                m_who_train  = m_mode_train;
                m_phase      = 2;
                if (m_cnt_sw < 65535) m_cnt_sw++;
            end
            default: begin
                if (issue) begin
                    if (m_run < MAXRUN) m_run++;
                    m_last_train = m_who_train;
                    if (m_who_train) m_cnt_tr = m_cnt_tr + 32'd1;
                    else m_cnt_te = m_cnt_te + 32'd1;
                end
                mine  = m_who_train ? vtr : vte;
                other = m_who_train ? vte : vtr;
                if (other && (!mine || m_run == MAXRUN)) m_phase = 0;
            end
        endcase
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, first, lastc, start, r3, mode_cyc, issue_cyc, cur_len;
        bit have, cur_tr, first_tr;
        int runs[$];

        model_reset();
        do_reset();

        // TEST-only stream of 5 tokens, retired as they go.
        n = 0; first = -1; lastc = -1; start = cyc;
        for (int i = 0; i < 20 && n < 5; i++) begin
            step(0, 1, 1, m_inflight > 0, 1);
            if (dut_issue) begin
                n++;
                if (first < 0) first = cyc;
                lastc = cyc;
            end
        end
        chk("t1_issues", 64'(n), 64'(5));
        chk("t1_latency", 64'(first - start), 64'(2));
        chk("t1_span", 64'(lastc - first), 64'(4));
        for (int i = 0; i < 4; i++) step(0, 0, 1, m_inflight > 0, 1);

        // Three TEST tokens in flight, then TRAIN asks: mode holds until the third retire.
        n = 0;
        for (int i = 0; i < 10 && n < 3; i++) begin
            step(0, 1, 1, 0, 0);
            if (dut_issue) n++;
        end
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0);
        chk("t2_hold_mode", 64'(o_mode), 64'(MODE_TEST));
        chk("t2_hold_busy", 64'(o_busy), 64'(1));
        for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 1);
        r3 = cyc; mode_cyc = -1; issue_cyc = -1;
        for (int i = 0; i < 10 && issue_cyc < 0; i++) begin
            step(1, 0, 1, 0, 0);
            if (mode_cyc < 0 && o_mode == MODE_TRAIN) mode_cyc = cyc;
            if (dut_issue && o_rdy_tr) issue_cyc = cyc;
        end
        chk("t2_mode_flip", 64'(mode_cyc - r3), 64'(1));
        chk("t2_first_train", 64'(issue_cyc - r3), 64'(1));

        // Both always valid: runs of MAXRUN, TEST first.
        do_reset();
        have = 0; cur_tr = 0; first_tr = 1; cur_len = 0;
        for (int i = 0; i < 100; i++) begin
            step(1, 1, 1, m_inflight > 0, 1);
            if (dut_issue) begin
                if (!have) begin
                    have = 1; cur_tr = o_rdy_tr; first_tr = o_rdy_tr; cur_len = 1;
                end else if (o_rdy_tr == cur_tr) begin
                    cur_len++;
                end else begin
                    runs.push_back(cur_len); cur_tr = o_rdy_tr; cur_len = 1;
                end
            end
        end
        chk("t3_first_is_test", 64'(first_tr), 64'(0));
        chk("t3_enough_runs", 64'(runs.size() >= 6), 64'(1));
        for (int i = 0; i < 6 && i < runs.size(); i++) chk($sformatf("t3_run%0d", i), 64'(runs[i]), 64'(MAXRUN));

        // Depth limit: no retires, only DEPTH tokens issue; one retire frees exactly one.
        do_reset();
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 1, 0, 0);
            if (dut_issue) n++;
        end
        chk("t4_full_issues", 64'(n), 64'(DEPTH));
        chk("t4_full_ready", 64'(o_rdy_te), 64'(0));
        step(0, 1, 1, 1, 1);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 0, 0);
            if (dut_issue) n++;
        end
        chk("t4_one_more", 64'(n), 64'(1));

        // Simultaneous issue/retire at 2 keeps 2; retire at 0 sets sticky error.
        step(0, 0, 1, 1, 1);
        step(0, 0, 1, 1, 1);
        step(0, 1, 1, 1, 1);
        step(0, 0, 1, 1, 1);
        step(0, 0, 1, 1, 1);
        step(0, 0, 1, 0, 0);
        chk("t5_no_err_yet", 64'(o_err), 64'(0));
        step(0, 0, 1, 1, 1);
        step(0, 0, 1, 0, 0);
        chk("t5_err_set", 64'(o_err), 64'(1));
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        chk("t5_err_sticky", 64'(o_err), 64'(1));

        // Reset while serving TRAIN with 3 in flight.
        do_reset();
        n = 0;
        for (int i = 0; i < 12 && n < 3; i++) begin
            step(1, 0, 1, 0, 0);
            if (dut_issue) n++;
        end
        chk("t6_train_issues", 64'(n), 64'(3));
        do_reset();

        // Random traffic; requesters keep valid until accepted.
        for (int i = 0; i < 3000; i++) begin
            bit vtr, vte;
            vtr = (v_tr && !took_tr) ? 1'b1 : ($urandom_range(0, 99) < 50);
            vte = (v_te && !took_te) ? 1'b1 : ($urandom_range(0, 99) < 50);
            step(vtr, vte, $urandom_range(0, 3) != 0,
                 (m_inflight > 0) && ($urandom_range(0, 1) == 1), $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
